// File: rtl/nway_flush_arbiter.sv
// N-channel request arbiter: one holding slot per channel, round-robin or fixed-priority
// pick into a registered issue stage, with per-channel flush-by-ID and a saturating drop counter.
module nway_flush_arbiter #(
    parameter int NUM_CHANNELS   = 4,
    parameter int CHANNEL_BITS   = 2,
    parameter int ADDRESS_WIDTH  = 8,
    parameter int ID_WIDTH       = 4,
    parameter int FIXED_PRIORITY = 0,
    parameter int COUNT_WIDTH    = 16
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_CHANNELS*ADDRESS_WIDTH-1:0] in_address,
    input  logic [NUM_CHANNELS*ID_WIDTH-1:0]  in_id,
    input  logic [NUM_CHANNELS-1:0]           in_valid,
    output logic [NUM_CHANNELS-1:0]           out_stall,
    input  logic [NUM_CHANNELS-1:0]           in_flush,
    input  logic [NUM_CHANNELS*ID_WIDTH-1:0]  in_flush_id,
    input  logic                              in_ready,
    output logic                              out_valid,
    output logic [CHANNEL_BITS-1:0]           out_choice,
    output logic [ADDRESS_WIDTH-1:0]          out_address,
    output logic [ID_WIDTH-1:0]               out_id,
    output logic [COUNT_WIDTH-1:0]            out_drop_count
);

    localparam int KILL_BITS = $clog2(NUM_CHANNELS + 2);

    logic [NUM_CHANNELS-1:0]  slot_valid;
    logic [ADDRESS_WIDTH-1:0] slot_address [NUM_CHANNELS];
    logic [ID_WIDTH-1:0]      slot_id      [NUM_CHANNELS];
    logic [CHANNEL_BITS-1:0]  rr_ptr;

    logic [NUM_CHANNELS-1:0]  slot_kill;
    logic [NUM_CHANNELS-1:0]  eligible;
    logic [NUM_CHANNELS-1:0]  grant;
    logic [NUM_CHANNELS-1:0]  slot_free;
    logic [NUM_CHANNELS-1:0]  capture;
    logic                     issue_kill;
    logic                     issue_free;
    logic                     grant_valid;
    logic [CHANNEL_BITS-1:0]  grant_index;
    logic [KILL_BITS-1:0]     kill_total;
    logic [COUNT_WIDTH:0]     count_sum;

    always_comb begin
        slot_kill = '0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            slot_kill[c] = in_flush[c] && slot_valid[c]
                           && (in_flush_id[c*ID_WIDTH +: ID_WIDTH] == slot_id[c]);
        end
    end

    // A transfer accepted this cycle wins over a flush of the issue register.
    assign issue_kill = out_valid && !in_ready && in_flush[out_choice]
                        && (in_flush_id[out_choice*ID_WIDTH +: ID_WIDTH] == out_id);
    assign issue_free = !out_valid || in_ready || issue_kill;
    assign eligible   = slot_valid & ~slot_kill;

    always_comb begin
        int idx;
        idx         = 0;
        grant_valid = 1'b0;
        grant_index = '0;
        grant       = '0;
        if (issue_free) begin
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                if (FIXED_PRIORITY != 0) begin
                    idx = i;
                end else begin
                    idx = int'(rr_ptr) + 1 + i;
                    if (idx >= NUM_CHANNELS) idx = idx - NUM_CHANNELS;
                end
                if (!grant_valid && eligible[idx]) begin
                    grant_valid = 1'b1;
                    grant_index = idx[CHANNEL_BITS-1:0];
                end
            end
            if (grant_valid) grant[grant_index] = 1'b1;
        end
    end

    assign slot_free = ~slot_valid | grant | slot_kill;
    assign out_stall = slot_valid & ~slot_free;
    assign capture   = in_valid & ~out_stall;

    always_comb begin
        kill_total = KILL_BITS'(issue_kill);
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            kill_total = kill_total + KILL_BITS'(slot_kill[c]);
        end
        count_sum = {1'b0, out_drop_count} + (COUNT_WIDTH+1)'(kill_total);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            slot_valid     <= '0;
            rr_ptr         <= CHANNEL_BITS'(NUM_CHANNELS - 1);
            out_valid      <= 1'b0;
            out_choice     <= '0;
            out_address    <= '0;
            out_id         <= '0;
            out_drop_count <= '0;
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                slot_address[c] <= '0;
                slot_id[c]      <= '0;
            end
        end else begin
            // Capture beats the slot draining through grant or kill in the same cycle.
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                if (capture[c]) begin
                    slot_valid[c]   <= 1'b1;
                    slot_address[c] <= in_address[c*ADDRESS_WIDTH +: ADDRESS_WIDTH];
                    slot_id[c]      <= in_id[c*ID_WIDTH +: ID_WIDTH];
                end else if (slot_free[c]) begin
                    slot_valid[c] <= 1'b0;
                end
            end
            if (issue_free) begin
                out_valid <= grant_valid;
                if (grant_valid) begin
                    out_choice  <= grant_index;
                    out_address <= slot_address[grant_index];
                    out_id      <= slot_id[grant_index];
                    rr_ptr      <= grant_index;
                end
            end
            if (count_sum[COUNT_WIDTH]) out_drop_count <= '1;
            else                        out_drop_count <= count_sum[COUNT_WIDTH-1:0];
        end
    end

endmodule

// File: tb/tb_nway_flush_arbiter.sv
// Directed bench for nway_flush_arbiter: a round-robin instance with a narrow drop counter
// and a fixed-priority instance sharing the same stimulus.
module tb_nway_flush_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] in_address;
    logic [15:0] in_id;
    logic [3:0]  in_valid;
    logic [3:0]  in_flush;
    logic [15:0] in_flush_id;
    logic        in_ready;

    logic [3:0]  out_stall;
    logic        out_valid;
    logic [1:0]  out_choice;
    logic [7:0]  out_address;
    logic [3:0]  out_id;
    logic [3:0]  out_drop_count;

    logic [3:0]  fp_stall;
    logic        fp_valid;
    logic [1:0]  fp_choice;
    logic [7:0]  fp_address;
    logic [3:0]  fp_id;
    logic [15:0] fp_count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    nway_flush_arbiter #(.COUNT_WIDTH(4)) dut (
        .clk(clk), .reset(reset),
        .in_address(in_address), .in_id(in_id), .in_valid(in_valid),
        .out_stall(out_stall), .in_flush(in_flush), .in_flush_id(in_flush_id),
        .in_ready(in_ready), .out_valid(out_valid), .out_choice(out_choice),
        .out_address(out_address), .out_id(out_id), .out_drop_count(out_drop_count)
    );

    nway_flush_arbiter #(.FIXED_PRIORITY(1)) dut_fp (
        .clk(clk), .reset(reset),
        .in_address(in_address), .in_id(in_id), .in_valid(in_valid),
        .out_stall(fp_stall), .in_flush(in_flush), .in_flush_id(in_flush_id),
        .in_ready(in_ready), .out_valid(fp_valid), .out_choice(fp_choice),
        .out_address(fp_address), .out_id(fp_id), .out_drop_count(fp_count)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int c, input logic [7:0] a, input logic [3:0] id);
        in_address[c*8 +: 8] = a;
        in_id[c*4 +: 4]      = id;
    endtask

    task automatic set_flush(input int c, input logic [3:0] id);
        in_flush_id[c*4 +: 4] = id;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        in_valid = '0;
        in_flush = '0;
        cyc();
        reset = 1'b0;
    endtask

    // Fill every slot plus the issue register, then flush all five entries at once.
    task automatic fill_flush(input int exp_count);
        in_ready = 1'b0;
        for (int c = 0; c < 4; c++) set_req(c, 8'h50 + 8'(c), 4'(c));
        in_valid = 4'hF;
        cyc();
        cyc();
        in_valid = '0;
        in_flush = 4'hF;
        for (int c = 0; c < 4; c++) set_flush(c, 4'(c));
        @(negedge clk);
        chk("sat_stall", out_stall, 0);
        cyc();
        in_flush = '0;
        chk("sat_count", out_drop_count, exp_count);
        chk("sat_valid", out_valid, 0);
    endtask

    initial begin
        reset = 1'b1;
        in_address = '0; in_id = '0; in_valid = '0;
        in_flush = '0; in_flush_id = '0; in_ready = 1'b0;
        cyc();
        cyc();
        chk("rst_valid", out_valid, 0);
        chk("rst_choice", out_choice, 0);
        chk("rst_address", out_address, 0);
        chk("rst_id", out_id, 0);
        chk("rst_count", out_drop_count, 0);
        chk("rst_stall", out_stall, 0);
        reset = 1'b0;

        // single request on channel 2
        set_req(2, 8'h3C, 4'd5);
        in_valid = 4'b0100;
        in_ready = 1'b1;
        @(negedge clk);
        chk("single_stall_in", out_stall, 0);
        cyc();
        in_valid = '0;
        @(negedge clk);
        chk("single_stall_held", out_stall, 0);
        cyc();
        chk("single_valid", out_valid, 1);
        chk("single_choice", out_choice, 2);
        chk("single_address", out_address, 8'h3C);
        chk("single_id", out_id, 5);
        cyc();
        chk("single_drain", out_valid, 0);
        do_reset();

        // all channels busy: round-robin rotates, fixed priority sticks on channel 0
        for (int c = 0; c < 4; c++) set_req(c, 8'h10 + 8'(c), 4'(c));
        in_valid = 4'hF;
        in_ready = 1'b1;
        cyc();
        cyc();
        for (int k = 0; k < 5; k++) begin
            chk("rr_valid", out_valid, 1);
            chk("rr_choice", out_choice, k % 4);
            chk("rr_address", out_address, 8'h10 + (k % 4));
            chk("fp_choice", fp_choice, 0);
            chk("fp_valid", fp_valid, 1);
            @(negedge clk);
            chk("fp_stall", fp_stall, 4'b1110);
            cyc();
        end
        do_reset();

        // backpressure with channel 1 issued and its slot full
        set_req(1, 8'h21, 4'd1);
        in_valid = 4'b0010;
        in_ready = 1'b0;
        cyc();
        set_req(1, 8'h22, 4'd2);
        cyc();
        set_req(1, 8'h23, 4'd3);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_stall", out_stall, 4'b0010);
            cyc();
            chk("bp_valid", out_valid, 1);
            chk("bp_address", out_address, 8'h21);
            chk("bp_id", out_id, 1);
            chk("bp_choice", out_choice, 1);
        end
        in_valid = '0;
        in_ready = 1'b1;
        cyc();
        chk("bp_next_address", out_address, 8'h22);
        chk("bp_next_id", out_id, 2);
        chk("bp_next_valid", out_valid, 1);
        cyc();
        chk("bp_empty", out_valid, 0);
        do_reset();

        // flush of a held slot drops stall and lets a new request in
        set_req(3, 8'h30, 4'd8);
        in_valid = 4'b1000;
        in_ready = 1'b0;
        cyc();
        set_req(3, 8'h39, 4'd9);
        cyc();
        chk("fl_issue_id", out_id, 8);
        in_flush = 4'b1000;
        set_flush(3, 4'd9);
        set_req(3, 8'h3A, 4'd10);
        @(negedge clk);
        chk("fl_stall", out_stall, 0);
        cyc();
        in_flush = '0;
        in_valid = '0;
        chk("fl_count", out_drop_count, 1);
        chk("fl_hold_id", out_id, 8);
        in_ready = 1'b1;
        cyc();
        chk("fl_next_id", out_id, 10);
        chk("fl_next_address", out_address, 8'h3A);
        cyc();
        chk("fl_empty", out_valid, 0);
        chk("fl_count_after", out_drop_count, 1);

        // flush of the issue register, with and without in_ready
        in_ready = 1'b0;
        set_req(0, 8'h44, 4'd4);
        in_valid = 4'b0001;
        cyc();
        in_valid = '0;
        cyc();
        chk("ik_valid", out_valid, 1);
        chk("ik_id", out_id, 4);
        in_flush = 4'b0001;
        set_flush(0, 4'd5);
        cyc();
        chk("ik_nomatch_valid", out_valid, 1);
        chk("ik_nomatch_count", out_drop_count, 1);
        set_flush(0, 4'd4);
        cyc();
        in_flush = '0;
        chk("ik_killed", out_valid, 0);
        chk("ik_count", out_drop_count, 2);
        set_req(0, 8'h45, 4'd4);
        in_valid = 4'b0001;
        cyc();
        in_valid = '0;
        cyc();
        chk("ik2_address", out_address, 8'h45);
        in_flush = 4'b0001;
        in_ready = 1'b1;
        cyc();
        in_flush = '0;
        chk("ik2_valid", out_valid, 0);
        chk("ik2_count", out_drop_count, 2);

        // five kills per round drive the 4-bit counter into saturation
        fill_flush(7);
        fill_flush(12);
        fill_flush(15);
        fill_flush(15);

        // reset in the middle of traffic
        for (int c = 0; c < 4; c++) set_req(c, 8'h60 + 8'(c), 4'(c));
        in_valid = 4'hF;
        in_ready = 1'b1;
        cyc();
        cyc();
        cyc();
        chk("mid_valid", out_valid, 1);
        reset = 1'b1;
        cyc();
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_choice", out_choice, 0);
        chk("mid_rst_address", out_address, 0);
        chk("mid_rst_id", out_id, 0);
        chk("mid_rst_count", out_drop_count, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("mid_rst_stall", out_stall, 0);
        cyc();
        cyc();
        chk("post_rst_choice", out_choice, 0);
        chk("post_rst_address", out_address, 8'h60);
        chk("post_rst_valid", out_valid, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
